// File: rtl/imuldiv_div_arbiter_pkg.sv
// Shared types and constants for the two-port divider arbiter.
// Widths match the existing divide request/response message definitions.
package imuldiv_div_arbiter_pkg;

    localparam int unsigned DivReqAWidth       = 32;
    localparam int unsigned DivReqBWidth       = 32;
    localparam int unsigned DivRespResultWidth = 64;
    localparam int unsigned PortIdxWidth       = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                    fn;
        logic [DivReqAWidth-1:0] a;
        logic [DivReqBWidth-1:0] b;
    } divreq_msg_t;

    function automatic logic [PortIdxWidth-1:0] other_port(input logic [PortIdxWidth-1:0] port);
        return ~port;
    endfunction

endpackage

// File: rtl/imuldiv_rr_arb2.sv
// Combinational two-input grant; prio picks the winner only when both ports are valid.
module imuldiv_rr_arb2 (
    input  logic val0,
    input  logic val1,
    input  logic prio,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = val0 & (~val1 | ~prio);
        grant1 = val1 & (~val0 | prio);
    end

endmodule

// File: rtl/imuldiv_div_arbiter.sv
// Shares one iterative divider between two requesters, one op in flight at a time.
// The result is returned only to the port recorded as owner when the op was accepted.
module imuldiv_div_arbiter
    import imuldiv_div_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          req0_msg_fn,
    input  logic [DivReqAWidth-1:0]       req0_msg_a,
    input  logic [DivReqBWidth-1:0]       req0_msg_b,
    input  logic                          req0_val,
    output logic                          req0_rdy,

    input  logic                          req1_msg_fn,
    input  logic [DivReqAWidth-1:0]       req1_msg_a,
    input  logic [DivReqBWidth-1:0]       req1_msg_b,
    input  logic                          req1_val,
    output logic                          req1_rdy,

    output logic [DivRespResultWidth-1:0] resp0_msg_result,
    output logic                          resp0_val,
    input  logic                          resp0_rdy,

    output logic [DivRespResultWidth-1:0] resp1_msg_result,
    output logic                          resp1_val,
    input  logic                          resp1_rdy,

    output logic                          divreq_msg_fn,
    output logic [DivReqAWidth-1:0]       divreq_msg_a,
    output logic [DivReqBWidth-1:0]       divreq_msg_b,
    output logic                          divreq_val,
    input  logic                          divreq_rdy,

    input  logic [DivRespResultWidth-1:0] divresp_msg_result,
    input  logic                          divresp_val,
    output logic                          divresp_rdy
);

    arb_state_e                    state_q, state_d;
    logic                          prio_q, prio_d;
    logic                          owner_q, owner_d;
    divreq_msg_t                   op_q, op_d;
    logic [DivRespResultWidth-1:0] result_q, result_d;

    logic arb_prio;
    logic grant0, grant1;
    logic resp_hs;

    // Fixed-priority builds pin the pointer so port 0 always wins a tie.
    assign arb_prio = RR_EN ? prio_q : 1'b0;

    imuldiv_rr_arb2 u_rr_arb2 (
        .val0   (req0_val),
        .val1   (req1_val),
        .prio   (arb_prio),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign resp_hs = (state_q == RESP) && (owner_q ? resp1_rdy : resp0_rdy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    op_d    = grant1 ? {req1_msg_fn, req1_msg_a, req1_msg_b}
                                     : {req0_msg_fn, req0_msg_a, req0_msg_b};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (divreq_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (divresp_val) begin
                    result_d = divresp_msg_result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (resp_hs) begin
                    prio_d  = RR_EN ? other_port(owner_q) : 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_rdy         = 1'b0;
        req1_rdy         = 1'b0;
        resp0_val        = 1'b0;
        resp1_val        = 1'b0;
        divreq_val       = 1'b0;
        divresp_rdy      = 1'b0;
        divreq_msg_fn    = op_q.fn;
        divreq_msg_a     = op_q.a;
        divreq_msg_b     = op_q.b;
        resp0_msg_result = result_q;
        resp1_msg_result = result_q;
        case (state_q)
            IDLE: begin
                req0_rdy = grant0;
                req1_rdy = grant1;
            end
            ISSUE:   divreq_val  = 1'b1;
            WAIT:    divresp_rdy = 1'b1;
            RESP: begin
                resp0_val = ~owner_q;
                resp1_val = owner_q;
            end
            default: ;
        endcase
    end

    // Protocol invariants the requesters and divider depend on.
    assert property (@(posedge clk) disable iff (reset) !(req0_rdy && req1_rdy));
    assert property (@(posedge clk) disable iff (reset) !(resp0_val && resp1_val));
    assert property (@(posedge clk) disable iff (reset)
        (divreq_val && !divreq_rdy) |=>
            (divreq_val && $stable(divreq_msg_fn) && $stable(divreq_msg_a) && $stable(divreq_msg_b)));
    assert property (@(posedge clk) disable iff (reset)
        (resp0_val && !resp0_rdy) |=> (resp0_val && $stable(resp0_msg_result)));
    assert property (@(posedge clk) disable iff (reset)
        (resp1_val && !resp1_rdy) |=> (resp1_val && $stable(resp1_msg_result)));

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// Bench for imuldiv_div_arbiter: per-port request queues, a stub divider, and a
// reference model of results and grant order; a second instance runs fixed priority.
module tb_imuldiv_div_arbiter;

    localparam int TimeoutCycles = 2000;

    typedef struct packed {
        logic        fn;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req0_msg_fn, req1_msg_fn;
    logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
    logic        req0_val, req1_val, req0_rdy, req1_rdy;
    logic [63:0] resp0_msg_result, resp1_msg_result;
    logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result = '0;
    logic        divresp_val, divresp_rdy;

    logic        f_req0_msg_fn = 1'b0, f_req1_msg_fn = 1'b1;
    logic [31:0] f_req0_msg_a = 32'd9, f_req0_msg_b = 32'd3;
    logic [31:0] f_req1_msg_a = 32'd8, f_req1_msg_b = 32'd2;
    logic        f_req0_val = 1'b1, f_req1_val = 1'b1, f_req0_rdy, f_req1_rdy;
    logic [63:0] f_resp0_msg_result, f_resp1_msg_result;
    logic        f_resp0_val, f_resp1_val;
    logic        f_resp0_rdy = 1'b1, f_resp1_rdy = 1'b1;
    logic        f_divreq_msg_fn;
    logic [31:0] f_divreq_msg_a, f_divreq_msg_b;
    logic        f_divreq_val, f_divreq_rdy;
    logic [63:0] f_divresp_msg_result = '0;
    logic        f_divresp_val, f_divresp_rdy;

    imuldiv_div_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
        .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
        .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
        .divresp_rdy(divresp_rdy)
    );

    imuldiv_div_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_msg_fn(f_req0_msg_fn), .req0_msg_a(f_req0_msg_a), .req0_msg_b(f_req0_msg_b),
        .req0_val(f_req0_val), .req0_rdy(f_req0_rdy),
        .req1_msg_fn(f_req1_msg_fn), .req1_msg_a(f_req1_msg_a), .req1_msg_b(f_req1_msg_b),
        .req1_val(f_req1_val), .req1_rdy(f_req1_rdy),
        .resp0_msg_result(f_resp0_msg_result), .resp0_val(f_resp0_val),
        .resp0_rdy(f_resp0_rdy),
        .resp1_msg_result(f_resp1_msg_result), .resp1_val(f_resp1_val),
        .resp1_rdy(f_resp1_rdy),
        .divreq_msg_fn(f_divreq_msg_fn), .divreq_msg_a(f_divreq_msg_a),
        .divreq_msg_b(f_divreq_msg_b), .divreq_val(f_divreq_val), .divreq_rdy(f_divreq_rdy),
        .divresp_msg_result(f_divresp_msg_result), .divresp_val(f_divresp_val),
        .divresp_rdy(f_divresp_rdy)
    );

    // Stub divider with programmable latency and an input stall.
    int   div_lat = 4;
    bit   div_stall = 1'b0;
    logic stub_busy;
    int   stub_cnt;
    op_t  stub_op;
    op_t  div_log[$];

    assign divreq_rdy = !stub_busy && !divresp_val && !div_stall;

    always @(posedge clk) begin
        if (reset) begin
            stub_busy   <= 1'b0;
            divresp_val <= 1'b0;
            stub_cnt    <= 0;
        end else begin
            if (divresp_val && divresp_rdy) divresp_val <= 1'b0;
            if (divreq_val && divreq_rdy) begin
                stub_op <= {divreq_msg_fn, divreq_msg_a, divreq_msg_b};
                div_log.push_back({divreq_msg_fn, divreq_msg_a, divreq_msg_b});
                stub_busy <= 1'b1;
                stub_cnt  <= div_lat;
            end else if (stub_busy) begin
                if (stub_cnt <= 1) begin
                    stub_busy          <= 1'b0;
                    divresp_val        <= 1'b1;
                    divresp_msg_result <= {stub_op.a % stub_op.b, stub_op.a / stub_op.b};
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    assign f_divreq_rdy = 1'b1;
    always @(posedge clk) begin
        if (reset) begin
            f_divresp_val <= 1'b0;
        end else if (f_divreq_val) begin
            f_divresp_val        <= 1'b1;
            f_divresp_msg_result <= {32'd0, f_divreq_msg_a};
        end else if (f_divresp_rdy) begin
            f_divresp_val <= 1'b0;
        end
    end

    // Requester/responder agent: samples at negedge, updates inputs just after posedge.
    op_t         q0[$], q1[$];
    logic [63:0] got0[$], got1[$];
    int          grant_log[$], grant_cyc[$], resp_cyc[$], f_grants[$];
    int          cyc = 0;
    bit          rand_rdy = 1'b0, rdy0_set = 1'b1, rdy1_set = 1'b1;

    initial begin
        bit          hs0, hs1, r0, r1;
        logic [63:0] rv0, rv1;
        req0_val = 1'b0; req1_val = 1'b0;
        req0_msg_fn = 1'b0; req0_msg_a = '0; req0_msg_b = '0;
        req1_msg_fn = 1'b0; req1_msg_a = '0; req1_msg_b = '0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            hs0 = !reset && req0_val && req0_rdy;
            hs1 = !reset && req1_val && req1_rdy;
            r0  = !reset && resp0_val && resp0_rdy;
            r1  = !reset && resp1_val && resp1_rdy;
            rv0 = resp0_msg_result;
            rv1 = resp1_msg_result;
            if (!reset && f_req0_val && f_req0_rdy) f_grants.push_back(0);
            if (!reset && f_req1_val && f_req1_rdy) f_grants.push_back(1);
            @(posedge clk);
            #1;
            if (hs0) begin q0.delete(0); grant_log.push_back(0); grant_cyc.push_back(cyc); end
            if (hs1) begin q1.delete(0); grant_log.push_back(1); grant_cyc.push_back(cyc); end
            if (r0) begin got0.push_back(rv0); resp_cyc.push_back(cyc); end
            if (r1) begin got1.push_back(rv1); resp_cyc.push_back(cyc); end
            req0_val = (q0.size() != 0);
            req1_val = (q1.size() != 0);
            if (q0.size() != 0) {req0_msg_fn, req0_msg_a, req0_msg_b} = q0[0];
            if (q1.size() != 0) {req1_msg_fn, req1_msg_a, req1_msg_b} = q1[0];
            resp0_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy0_set;
            resp1_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy1_set;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [63:0] div_model(input op_t o);
        return {o.a % o.b, o.a / o.b};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.fn = 1'($urandom_range(0, 1));
        o.a  = $urandom;
        o.b  = $urandom_range(1, 5000);
        return o;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete(); got0.delete(); got1.delete();
        grant_log.delete(); grant_cyc.delete(); resp_cyc.delete(); div_log.delete();
        f_grants.delete();
        div_stall = 1'b0; rand_rdy = 1'b0; rdy0_set = 1'b1; rdy1_set = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int n1, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TimeoutCycles; i++) begin
            if (got0.size() >= n0 && got1.size() >= n1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        do_reset();
        @(negedge clk);
        outs = {req0_rdy, req1_rdy, resp0_val, resp1_val, divreq_val, divresp_rdy,
                f_resp0_val, f_resp1_val};
        n_checks++;
        if (outs !== 8'b0) $display("FAIL reset_ctrl: got %b expected %b", outs, 8'b0);
        else n_pass++;
        n_checks++;
        if (resp0_msg_result !== 64'd0 || resp1_msg_result !== 64'd0)
            $display("FAIL reset_result: got %h/%h expected 0", resp0_msg_result,
                     resp1_msg_result);
        else n_pass++;
        n_checks++;
        if ({divreq_msg_fn, divreq_msg_a, divreq_msg_b} !== 65'd0)
            $display("FAIL reset_operands: got %h expected 0",
                     {divreq_msg_fn, divreq_msg_a, divreq_msg_b});
        else n_pass++;
        step(1);
    endtask

    task automatic test_single();
        op_t op;
        int  t_acc, t_resp;
        bit  saw1, ok;
        do_reset();
        div_lat = 33;
        op = {1'b0, 32'd100, 32'd7};
        q0.push_back(op);
        t_acc = -1; t_resp = -1; saw1 = 1'b0;
        for (int i = 0; i < TimeoutCycles && t_resp < 0; i++) begin
            @(negedge clk);
            if (req1_rdy || resp1_val) saw1 = 1'b1;
            if (t_acc < 0 && req0_val && req0_rdy) t_acc = i;
            if (resp0_val) t_resp = i;
        end
        n_checks++;
        if (resp0_msg_result !== {32'd2, 32'd14})
            $display("FAIL single_result: got %h expected %h", resp0_msg_result,
                     {32'd2, 32'd14});
        else n_pass++;
        n_checks++;
        if (t_acc < 0 || t_resp - t_acc !== 36)
            $display("FAIL single_latency: got %0d expected %0d", t_resp - t_acc, 36);
        else n_pass++;
        step(1);
        wait_done(1, 0, ok);
        n_checks++;
        if (!ok || got0[0] !== {32'd2, 32'd14})
            $display("FAIL single_handshake: got ok=%0d expected ok=1", ok);
        else n_pass++;
        n_checks++;
        if (saw1 !== 1'b0 || got1.size() !== 0)
            $display("FAIL single_port1_quiet: got %0d expected 0", saw1);
        else n_pass++;
        n_checks++;
        if (div_log.size() !== 1 || div_log[0] !== op)
            $display("FAIL single_divreq: got %0d ops expected 1 op %h", div_log.size(), op);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        bit ok;
        int g0, g1;
        do_reset();
        div_lat = 4;
        q0.push_back({1'b0, 32'd20, 32'd3});
        q1.push_back({1'b0, 32'd45, 32'd6});
        wait_done(1, 1, ok);
        g0 = grant_log.size() > 0 ? grant_log[0] : -1;
        g1 = grant_log.size() > 1 ? grant_log[1] : -1;
        n_checks++;
        if (!ok || g0 !== 0 || g1 !== 1)
            $display("FAIL simul_order: got %0d,%0d expected 0,1", g0, g1);
        else n_pass++;
        n_checks++;
        if (got0.size() < 1 || got0[0] !== {32'd2, 32'd6})
            $display("FAIL simul_resp0: got %h expected %h", got0.size() ? got0[0] : 64'hx,
                     {32'd2, 32'd6});
        else n_pass++;
        n_checks++;
        if (got1.size() < 1 || got1[0] !== {32'd3, 32'd7})
            $display("FAIL simul_resp1: got %h expected %h", got1.size() ? got1[0] : 64'hx,
                     {32'd3, 32'd7});
        else n_pass++;
    endtask

    task automatic test_fairness();
        op_t p0[6], p1[6];
        bit  ok;
        do_reset();
        div_lat = $urandom_range(1, 6);
        for (int k = 0; k < 6; k++) begin
            p0[k] = rand_op();
            p1[k] = rand_op();
            q0.push_back(p0[k]);
            q1.push_back(p1[k]);
        end
        wait_done(6, 6, ok);
        n_checks++;
        if (!ok) $display("FAIL fair_done: got %0d/%0d expected 6/6", got0.size(), got1.size());
        else n_pass++;
        for (int k = 0; k < 6 && ok; k++) begin
            n_checks++;
            if (grant_log[k] !== k % 2)
                $display("FAIL fair_grant%0d: got %0d expected %0d", k, grant_log[k], k % 2);
            else n_pass++;
            n_checks++;
            if (got0[k] !== div_model(p0[k]) || got1[k] !== div_model(p1[k]))
                $display("FAIL fair_result%0d: got %h/%h expected %h/%h", k, got0[k], got1[k],
                         div_model(p0[k]), div_model(p1[k]));
            else n_pass++;
            n_checks++;
            if (div_log[2 * k] !== p0[k] || div_log[2 * k + 1] !== p1[k])
                $display("FAIL fair_divreq%0d: got %h expected %h", k, div_log[2 * k], p0[k]);
            else n_pass++;
        end
        for (int i = 0; i < TimeoutCycles && f_grants.size() < 6; i++) step(1);
        n_checks++;
        if (f_grants.size() < 6) $display("FAIL fixed_done: got %0d expected 6", f_grants.size());
        else n_pass++;
        for (int k = 0; k < 6 && k < f_grants.size(); k++) begin
            n_checks++;
            if (f_grants[k] !== 0)
                $display("FAIL fixed_grant%0d: got %0d expected 0", k, f_grants[k]);
            else n_pass++;
        end
    endtask

    task automatic test_stalls();
        op_t op0, op1;
        bit  ok, seen;
        do_reset();
        div_lat = 3;
        div_stall = 1'b1;
        rdy1_set = 1'b0;
        op0 = rand_op();
        op1 = rand_op();
        q1.push_back(op1);
        for (int i = 0; i < TimeoutCycles && grant_log.size() == 0; i++) step(1);
        q0.push_back(op0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (divreq_val !== 1'b1 || {divreq_msg_fn, divreq_msg_a, divreq_msg_b} !== op1 ||
                req0_rdy !== 1'b0)
                $display("FAIL stall_issue%0d: got val=%b msg=%h expected val=1 msg=%h", i,
                         divreq_val, {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, op1);
            else n_pass++;
        end
        step(1);
        div_stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TimeoutCycles && !seen; i++) begin
            @(negedge clk);
            seen = resp1_val;
        end
        n_checks++;
        if (!seen) $display("FAIL stall_resp_seen: got 0 expected 1");
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp1_val !== 1'b1 || resp1_msg_result !== div_model(op1) || resp0_val !== 1'b0 ||
                req0_rdy !== 1'b0 || div_log.size() !== 1)
                $display("FAIL stall_resp%0d: got val=%b res=%h expected val=1 res=%h", i,
                         resp1_val, resp1_msg_result, div_model(op1));
            else n_pass++;
        end
        step(1);
        rdy1_set = 1'b1;
        wait_done(1, 1, ok);
        n_checks++;
        if (!ok || grant_log.size() !== 2 || grant_log[0] !== 1 || grant_log[1] !== 0)
            $display("FAIL stall_order: got %0d grants expected 1,0", grant_log.size());
        else n_pass++;
        n_checks++;
        if (!ok || got1[0] !== div_model(op1) || got0[0] !== div_model(op0) ||
            div_log.size() !== 2)
            $display("FAIL stall_results: got ok=%0d divops=%0d expected ok=1 divops=2", ok,
                     div_log.size());
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        op_t opa, opb, opc, opd;
        bit  ok, in_wait;
        logic [5:0] outs;
        do_reset();
        div_lat = 20;
        opa = rand_op(); opb = rand_op(); opc = rand_op(); opd = rand_op();
        q0.push_back(opa);
        wait_done(1, 0, ok);
        q1.push_back(opb);
        in_wait = 1'b0;
        for (int i = 0; i < TimeoutCycles && !in_wait; i++) begin
            @(negedge clk);
            in_wait = divresp_rdy;
        end
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        outs = {req0_rdy, req1_rdy, resp0_val, resp1_val, divreq_val, divresp_rdy};
        n_checks++;
        if (!in_wait || outs !== 6'b0)
            $display("FAIL midreset_idle: got %b expected %b", outs, 6'b0);
        else n_pass++;
        step(1);
        q0.push_back(opc);
        q1.push_back(opd);
        wait_done(2, 1, ok);
        step(3);
        n_checks++;
        if (!ok || grant_log.size() !== 4 || grant_log[2] !== 0 || grant_log[3] !== 1)
            $display("FAIL midreset_prio: got %0d grants expected 0 then 1 after reset",
                     grant_log.size());
        else n_pass++;
        n_checks++;
        if (!ok || got0[1] !== div_model(opc) || got1.size() !== 1 || got1[0] !== div_model(opd))
            $display("FAIL midreset_results: got %0d port1 responses expected 1", got1.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        div_lat = 2;
        for (int k = 0; k < 3; k++) q0.push_back(rand_op());
        wait_done(3, 0, ok);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (!ok || grant_cyc[k + 1] !== resp_cyc[k] + 1)
                $display("FAIL b2b_gap%0d: got %0d expected %0d", k,
                         ok ? grant_cyc[k + 1] : -1, ok ? resp_cyc[k] + 1 : -1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [63:0] exp0[$], exp1[$];
        op_t o;
        bit  ok;
        do_reset();
        rand_rdy = 1'b1;
        div_lat = $urandom_range(1, 5);
        for (int k = 0; k < 12; k++) begin
            o = rand_op();
            if ($urandom_range(0, 1) == 0) begin q0.push_back(o); exp0.push_back(div_model(o)); end
            else begin q1.push_back(o); exp1.push_back(div_model(o)); end
        end
        wait_done(exp0.size(), exp1.size(), ok);
        n_checks++;
        if (!ok) $display("FAIL rand_done: got %0d/%0d expected %0d/%0d", got0.size(),
                          got1.size(), exp0.size(), exp1.size());
        else n_pass++;
        for (int k = 0; k < exp0.size() && ok; k++) begin
            n_checks++;
            if (got0[k] !== exp0[k]) $display("FAIL rand_p0_%0d: got %h expected %h", k,
                                              got0[k], exp0[k]);
            else n_pass++;
        end
        for (int k = 0; k < exp1.size() && ok; k++) begin
            n_checks++;
            if (got1[k] !== exp1[k]) $display("FAIL rand_p1_%0d: got %h expected %h", k,
                                              got1[k], exp1[k]);
            else n_pass++;
        end
        rand_rdy = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_stalls();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
